// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 window generator and its line buffers.
package conv_pkg;

   localparam int CONV_DATA_W = 8;
   localparam int CONV_IMG_W  = 8;
   localparam int CONV_IMG_H  = 8;

   // Window geometry: 3x3, row-major.
   localparam int WIN_DIM = 3;
   localparam int WIN_N   = WIN_DIM * WIN_DIM;

   // One full window at the default pixel width, index 0 = top-left.
   typedef logic [CONV_DATA_W-1:0] win_t [WIN_N];

   // Row-major index of window element (r, c), r/c in 0..2.
   function automatic int win_idx(input int r, input int c);
      return r * WIN_DIM + c;
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// DEPTH-pixel delay line built as a circular RAM with one shared read/write
// pointer. dout is the pixel written DEPTH shifts ago; it is read before the
// same slot is overwritten on the shift edge.
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int DEPTH  = CONV_IMG_W,
   parameter int DATA_W = CONV_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     ptr;

   assign dout = mem[ptr];

   // Pointer walks the ring once per shift; contents need no reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (shift_en) begin
         if (ptr == PTR_LAST) begin
            ptr <= '0;
         end else begin
            ptr <= ptr + 1'b1;
         end
      end
   end

   // Overwrite the slot just read with the incoming pixel.
   always_ff @(posedge clk) begin
      if (shift_en) begin
         mem[ptr] <= din;
      end
   end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator. Buffers two image rows and, for every
// accepted pixel at row >= 2 and col >= 2, registers the 3x3 neighbourhood
// ending at that pixel. Valid/ready on both sides; a held window blocks
// further pixel intake so nothing is lost under backpressure.
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int IMG_W  = CONV_IMG_W,
   parameter int IMG_H  = CONV_IMG_H,
   parameter int DATA_W = CONV_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [DATA_W-1:0] pix_data,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [DATA_W-1:0] win_p1,
   output logic [DATA_W-1:0] win_p2,
   output logic [DATA_W-1:0] win_p3,
   output logic [DATA_W-1:0] win_p4,
   output logic [DATA_W-1:0] win_p5,
   output logic [DATA_W-1:0] win_p6,
   output logic [DATA_W-1:0] win_p7,
   output logic [DATA_W-1:0] win_p8,
   output logic [DATA_W-1:0] win_p9,
   output logic              win_last
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_FIRST = CW'(WIN_DIM - 1);
   localparam logic [RW-1:0] ROW_FIRST = RW'(WIN_DIM - 1);

   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic              accept;
   logic              emit;
   logic              frame_end;
   logic [DATA_W-1:0] lb0_out;
   logic [DATA_W-1:0] lb1_out;

   // Right-hand (newest) window column, top to bottom.
   logic [DATA_W-1:0] new_col [WIN_DIM];
   // Two older window columns per window row; [0] is leftmost.
   logic [DATA_W-1:0] hist    [WIN_DIM][2];
   // Window formed by the pixel currently being accepted.
   logic [DATA_W-1:0] win_nx  [WIN_N];
   // Registered window presented downstream.
   logic [DATA_W-1:0] win_q   [WIN_N];

   assign pix_ready = !win_valid || win_ready;
   assign accept    = pix_valid && pix_ready;
   assign emit      = (row >= ROW_FIRST) && (col >= COL_FIRST);
   assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

   assign new_col[0] = lb1_out;
   assign new_col[1] = lb0_out;
   assign new_col[2] = pix_data;

   // LB0 delays by one row: (r-1, c). LB1 chains off it: (r-2, c).
   conv_line_buffer #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W)
   ) u_lb0 (
      .clk      (clk),
      .rst      (rst),
      .shift_en (accept),
      .din      (pix_data),
      .dout     (lb0_out)
   );

   conv_line_buffer #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W)
   ) u_lb1 (
      .clk      (clk),
      .rst      (rst),
      .shift_en (accept),
      .din      (lb0_out),
      .dout     (lb1_out)
   );

   // Raster position of the next pixel; wraps frame to frame with no gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
               row <= '0;
            end else begin
               row <= row + 1'b1;
            end
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Assemble the window ending at the incoming pixel.
   always_comb begin
      for (int r = 0; r < WIN_DIM; r++) begin
         win_nx[win_idx(r, 0)] = hist[r][0];
         win_nx[win_idx(r, 1)] = hist[r][1];
         win_nx[win_idx(r, 2)] = new_col[r];
      end
   end

   // Shift the column history left on every accepted pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < WIN_DIM; r++) begin
            hist[r][0] <= '0;
            hist[r][1] <= '0;
         end
      end else if (accept) begin
         for (int r = 0; r < WIN_DIM; r++) begin
            hist[r][0] <= hist[r][1];
            hist[r][1] <= new_col[r];
         end
      end
   end

   // Output register and valid/last; an unconsumed window is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_valid <= 1'b0;
         win_last  <= 1'b0;
         for (int i = 0; i < WIN_N; i++) begin
            win_q[i] <= '0;
         end
      end else if (accept) begin
         win_valid <= emit;
         win_last  <= emit && frame_end;
         if (emit) begin
            for (int i = 0; i < WIN_N; i++) begin
               win_q[i] <= win_nx[i];
            end
         end
      end else if (win_ready) begin
         win_valid <= 1'b0;
         win_last  <= 1'b0;
      end
   end

   assign win_p1 = win_q[0];
   assign win_p2 = win_q[1];
   assign win_p3 = win_q[2];
   assign win_p4 = win_q[3];
   assign win_p5 = win_q[4];
   assign win_p6 = win_q[5];
   assign win_p7 = win_q[6];
   assign win_p8 = win_q[7];
   assign win_p9 = win_q[8];

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 4x4 and an 8x8 instance share stimulus, sel
// picks the active one. A frame-image model predicts every window.
module tb_conv_window_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       pix_valid;
   logic       win_ready;
   logic       sel;
   logic [7:0] pix_data;

   logic       pr4, pr8, wv4, wv8, wl4, wl8;
   logic [7:0] o4 [9];
   logic [7:0] o8 [9];
   logic [71:0] wd4, wd8, wd;
   logic       pr, wv, wl;

   conv_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut4 (
      .clk(clk), .rst(rst), .pix_valid(pix_valid && !sel), .pix_ready(pr4),
      .pix_data(pix_data), .win_valid(wv4), .win_ready(win_ready || sel),
      .win_p1(o4[0]), .win_p2(o4[1]), .win_p3(o4[2]), .win_p4(o4[3]),
      .win_p5(o4[4]), .win_p6(o4[5]), .win_p7(o4[6]), .win_p8(o4[7]),
      .win_p9(o4[8]), .win_last(wl4));

   conv_window_gen #(.IMG_W(8), .IMG_H(8), .DATA_W(8)) dut8 (
      .clk(clk), .rst(rst), .pix_valid(pix_valid && sel), .pix_ready(pr8),
      .pix_data(pix_data), .win_valid(wv8), .win_ready(win_ready || !sel),
      .win_p1(o8[0]), .win_p2(o8[1]), .win_p3(o8[2]), .win_p4(o8[3]),
      .win_p5(o8[4]), .win_p6(o8[5]), .win_p7(o8[6]), .win_p8(o8[7]),
      .win_p9(o8[8]), .win_last(wl8));

   assign wd4 = {o4[0], o4[1], o4[2], o4[3], o4[4], o4[5], o4[6], o4[7], o4[8]};
   assign wd8 = {o8[0], o8[1], o8[2], o8[3], o8[4], o8[5], o8[6], o8[7], o8[8]};
   assign wd  = sel ? wd8 : wd4;
   assign pr  = sel ? pr8 : pr4;
   assign wv  = sel ? wv8 : wv4;
   assign wl  = sel ? wl8 : wl4;

   // Hand-computed windows of the 4x4 ramp (pixel = 4r+c), {last, p1..p9}.
   localparam logic [72:0] W1 = {1'b0, 8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
   localparam logic [72:0] W2 = {1'b0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
   localparam logic [72:0] W3 = {1'b0, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14};
   localparam logic [72:0] W4 = {1'b1, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
   localparam logic [72:0] F2W1 = {1'b0, 8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106,
                                   8'd108, 8'd109, 8'd110};

   logic [7:0]  img [8][8];
   logic [72:0] exp_q [$];
   logic [72:0] lg [$];
   int n_acc, cur_w, cur_h, consumed, hold_cycles;
   int n_chk, n_fail;
   bit hold_prev, emit_prev, acc_prev;
   logic [72:0] prev_out;
   int rdy_mode, stall_cnt, pulse_cnt;
   bit stall_done;

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic chk_log(input string nm, input int idx, input logic [72:0] req);
      if (idx < lg.size()) begin
         chk(nm, 80'(lg[idx]), 80'(req));
      end else begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: window %0d missing, required=%h", nm, idx, req);
      end
   endtask

   // Neighbourhood of (r, c) taken straight from the current frame image.
   function automatic logic [71:0] model_win(input int r, input int c);
      logic [71:0] w;
      w = '0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            w = {w[63:0], img[r-2+dr][c-2+dc]};
      return w;
   endfunction

   // Per-cycle compare against the model, sampled mid-cycle.
   always @(negedge clk) begin
      logic [72:0] cur;
      int pos, r, c;
      cur = {wl, wd};
      if (rst) begin
         hold_prev = 0;
         emit_prev = 0;
         acc_prev  = 0;
      end else begin
         if (hold_prev)
            chk("hold_stable", {6'b0, wv, cur}, {6'b0, 1'b1, prev_out});
         if (emit_prev)
            chk("latency_valid", 80'(wv), 80'(1));
         else if (acc_prev)
            chk("no_window", 80'(wv), 80'(0));
         chk("pix_ready", 80'(pr), 80'(!wv || win_ready));
         if (wv && !win_ready) hold_cycles++;
         if (wv && win_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL spurious_window: actual=%h required=none", cur);
            end else begin
               chk("window", 80'(cur), 80'(exp_q.pop_front()));
            end
            lg.push_back(cur);
            consumed++;
         end
         acc_prev  = pix_valid && pr;
         emit_prev = 0;
         if (pix_valid && pr) begin
            pos = n_acc % (cur_w * cur_h);
            r = pos / cur_w;
            c = pos % cur_w;
            img[r][c] = pix_data;
            n_acc++;
            if (r >= 2 && c >= 2) begin
               exp_q.push_back({(r == cur_h-1) && (c == cur_w-1), model_win(r, c)});
               emit_prev = 1;
            end
         end
         hold_prev = wv && !win_ready;
         prev_out  = cur;
      end
   end

   // Downstream behaviour: always ready, one 3-cycle stall on window 2,
   // one-in-ten pulse like a multi-cycle convolution, or random.
   always begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         1: begin
            if (!stall_done && wv && consumed == 1) begin
               if (stall_cnt < 3) begin
                  win_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  win_ready  = 1'b1;
                  stall_done = 1;
               end
            end else begin
               win_ready = 1'b1;
            end
         end
         2: begin
            pulse_cnt++;
            win_ready = (pulse_cnt % 10 == 0);
         end
         3: win_ready = 1'($urandom_range(0, 1));
         default: win_ready = 1'b1;
      endcase
   end

   task automatic send(input logic [7:0] v);
      int t;
      bit acc;
      t = 0;
      acc = 0;
      pix_valid = 1'b1;
      pix_data  = v;
      while (!acc && t < 100) begin
         @(negedge clk);
         acc = pr;
         @(posedge clk);
         #1;
         t++;
      end
      if (!acc) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: actual=not accepted required=accepted");
      end
      pix_valid = 1'b0;
   endtask

   task automatic frame4(input int base, input int first_row, input int last_row);
      for (int r = first_row; r <= last_row; r++)
         for (int c = 0; c < 4; c++)
            send(8'(base + 4*r + c));
   endtask

   task automatic frame_rand(input int w, input int h);
      for (int k = 0; k < w*h; k++) begin
         while ($urandom_range(0, 99) < 30) begin
            pix_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         send(8'($urandom_range(0, 255)));
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || wv) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: actual=%0d pending required=0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic start_scn(input int mode);
      rdy_mode    = mode;
      lg.delete();
      consumed    = 0;
      hold_cycles = 0;
      stall_cnt   = 0;
      stall_done  = 0;
      pulse_cnt   = 0;
   endtask

   task automatic check_reset_state(input string nm);
      chk(nm, 80'({wv, wl, pr, wd}), 80'({1'b0, 1'b0, 1'b1, 72'd0}));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_reset_state("reset_state");
      exp_q.delete();
      n_acc = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      n_chk = 0; n_fail = 0; n_acc = 0;
      cur_w = 4; cur_h = 4;
      sel = 1'b0; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b1;
      start_scn(0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset_state");
      rst = 1'b0;

      // Ramp frame, always ready.
      start_scn(0);
      frame4(0, 0, 3);
      drain();
      chk("ramp_count", 80'(lg.size()), 80'(4));
      chk_log("ramp_w1", 0, W1);
      chk_log("ramp_w2", 1, W2);
      chk_log("ramp_w3", 2, W3);
      chk_log("ramp_w4", 3, W4);

      // Same frame, window 2 stalled for 3 cycles.
      start_scn(1);
      frame4(0, 0, 3);
      drain();
      chk("stall_cycles", 80'(hold_cycles), 80'(3));
      chk("stall_count", 80'(lg.size()), 80'(4));
      chk_log("stall_w1", 0, W1);
      chk_log("stall_w2", 1, W2);
      chk_log("stall_w3", 2, W3);
      chk_log("stall_w4", 3, W4);

      // Back-to-back frames, second offset by 100.
      start_scn(0);
      frame4(0, 0, 3);
      frame4(100, 0, 1);
      repeat (3) @(negedge clk);
      chk("frame2_rows01_silent", 80'(consumed), 80'(4));
      @(posedge clk);
      #1;
      frame4(100, 2, 3);
      drain();
      chk("b2b_count", 80'(lg.size()), 80'(8));
      chk_log("b2b_f1_last", 3, W4);
      chk_log("b2b_f2_first", 4, F2W1);

      // Reset after 6 pixels, then a fresh frame.
      start_scn(0);
      for (int k = 0; k < 6; k++) send(8'(200 + k));
      do_reset();
      start_scn(0);
      frame4(0, 0, 3);
      drain();
      chk("post_reset_count", 80'(lg.size()), 80'(4));
      chk_log("post_reset_w1", 0, W1);
      chk_log("post_reset_w2", 1, W2);
      chk_log("post_reset_w3", 2, W3);
      chk_log("post_reset_w4", 3, W4);

      // Slow consumer: one ready pulse every 10 cycles, two frames.
      start_scn(2);
      frame4(0, 0, 3);
      frame4(20, 0, 3);
      drain();
      chk("pulse_count", 80'(lg.size()), 80'(8));
      chk_log("pulse_w1", 0, W1);
      chk_log("pulse_w4", 3, W4);

      // 8x8 random pixels with idle gaps, then with random backpressure too.
      start_scn(0);
      sel = 1'b1;
      cur_w = 8; cur_h = 8;
      do_reset();
      start_scn(0);
      frame_rand(8, 8);
      drain();
      chk("rand8_count", 80'(lg.size()), 80'(36));
      start_scn(3);
      frame_rand(8, 8);
      drain();
      chk("rand8_bp_count", 80'(lg.size()), 80'(36));
      chk("rand8_bp_last", 80'(lg.size() > 0 ? lg[lg.size()-1][72] : 1'b0), 80'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 window generator that sits directly upstream of the 3x3 convolution stage. It accepts an 8-bit pixel stream in raster order and buffers the two previous image rows. For every pixel that completes a full 3x3 neighbourhood, it presents the nine pixels row-major on parallel outputs, matching the convolution's input1..input9 ordering. A valid/ready handshake on both sides lets the multi-cycle convolution apply backpressure without losing pixels.

## Interface
Parameters:
- IMG_W, default 8: image width in pixels; legal range 3..1024.
- IMG_H, default 8: image height in rows; legal range 3..1024.
- DATA_W, default 8: pixel width in bits.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: asynchronous, active-high reset.
- pix_valid, input, 1: pix_data holds a valid pixel.
- pix_ready, output, 1: block accepts a pixel this cycle.
- pix_data, input, DATA_W: incoming pixel, raster order (row 0 col 0 first).
- win_valid, output, 1: window outputs hold a valid window.
- win_ready, input, 1: downstream consumes the window this cycle.
- win_p1 .. win_p9, output, DATA_W each: window pixels, row-major; p1 is top-left, p9 is bottom-right.
- win_last, output, 1: qualifies the final window of a frame.

## Operation
- Accept: a pixel is accepted when pix_valid && pix_ready.
- pix_ready is combinational: pix_ready = !win_valid || win_ready.
- Position counters: col counts 0..IMG_W-1 and row counts 0..IMG_H-1. Both advance only on accept. col wraps to 0 and increments row. When row == IMG_H-1 and col == IMG_W-1, both counters wrap to 0; the next pixel starts a new frame, with no gap or control signal needed.
- Line buffers: two IMG_W-deep delay lines. LB0 outputs the pixel at (r-1, c) and LB1 outputs (r-2, c). Both shift on accept only.
- Window registers: a 3x3 shift array. Each accept shifts the columns left and loads a new right column of {LB1 out, LB0 out, pix_data}.
- Window emit: accepting pixel (r, c) with r >= 2 and c >= 2 produces a window:
  - p1..p3 = (r-2, c-2..c)
  - p4..p6 = (r-1, c-2..c)
  - p7..p9 = (r, c-2..c)
- Windows per frame: exactly (IMG_H-2)*(IMG_W-2). win_last = 1 only for the window from (IMG_H-1, IMG_W-1).
- Gating: pixels at col 0/1 or row 0/1 produce no window. Stale line-buffer data from a previous frame is never emitted because of this row/col gating.
- Output hold: while win_valid && !win_ready, all win_* outputs are held stable and no pixel is accepted.
- Arithmetic: pure data movement, no arithmetic on pixels. Counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide.

## Timing
- Reset values:
  - win_valid = 0, win_last = 0, win_p1..p9 = 0.
  - Counters = 0.
  - pix_ready = 1 (follows from win_valid = 0).
  - Line-buffer contents are don't-care.
- Latency: win_valid rises on the clock edge that accepts the completing pixel, i.e. 1 cycle after accept.
- Throughput: 1 pixel/cycle and 1 window/cycle when win_ready is held high.
- Simultaneous consume and accept (win_valid && win_ready with a pixel accepted in the same cycle): the next window is loaded on that edge. win_valid stays 1 if the new pixel completes a window, otherwise it falls to 0.
- win_ready while win_valid = 0: no effect.
- pix_valid gaps: no state change; counters and line buffers freeze.
- Reset mid-frame: an in-flight window is dropped and the counters restart at row 0, col 0. The next accepted pixel is treated as frame start.
- Downstream use: the convolution controller drives its en from win_valid and asserts win_ready only when idle. This stalls the generator for the convolution's multi-cycle duration.

## Structure
- Shared package conv_pkg holds DATA_W, default IMG_W/IMG_H, and the window type (array of 9 DATA_W pixels).
- One sub-module, conv_line_buffer: a parameterised DEPTH x DATA_W delay line with a shift-enable, built as a circular RAM with a single read/write pointer. It is instantiated twice, for LB0 and LB1.
- Top-level contents: counters, window shift array, output register, and handshake.

## Test plan
- 4x4 ramp frame, pixel = 4r+c, win_ready = 1, continuous pix_valid:
  - exactly 4 windows are produced;
  - first window p1..p9 = 0,1,2,4,5,6,8,9,10;
  - last window = 5,6,7,9,10,11,13,14,15 with win_last = 1 only on that window.
- Same frame, win_ready held low for 3 cycles on window 2:
  - window outputs stay stable and pix_ready = 0 throughout;
  - on release, the remaining windows are correct with no pixel lost or duplicated.
- Two back-to-back 4x4 frames, second frame pixel = 100+4r+c:
  - first window of frame 2 = 100,101,102,104,105,106,108,109,110;
  - no window is emitted for rows 0-1 of frame 2.
- Random pix_valid gaps (~30% idle) on an 8x8 frame: 36 windows match the golden model in order.
- rst asserted after 6 pixels of a 4x4 frame, then a fresh full frame:
  - outputs return to reset values immediately;
  - the fresh frame produces the same 4 windows as the first scenario.
- Downstream model mimicking a 10-cycle convolution (win_ready pulses once every 10 cycles): all windows are consumed exactly once with correct data.
